// File: rtl/uart_receiver_if.sv
// Serial RX line and received-byte outputs of the one-bit-per-clock UART receiver.
// The master drives the line; the slave is the receiver.
interface uart_receiver_if;
    logic       recieverInput;
    logic [7:0] byteRecieved;
    logic       done;

    modport master (
        output recieverInput,
        input  byteRecieved,
        input  done
    );

    modport slave (
        input  recieverInput,
        output byteRecieved,
        output done
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver, one bit per clock: 1 start, 8 data (LSB first), 1 stop, no parity.
// Pulses done for one cycle with the assembled byte when the stop bit is high.
module uart_receiver (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2,
        STOP  = 2'd3
    } uartUtil_e;

    uartUtil_e  stateCounter;
    uartUtil_e  nextState;
    logic [2:0] recieveCounter;
    logic [7:0] byteRecieved_q;
    logic       done_q;
    logic       shiftEn;

    always_comb begin
        nextState = IDLE;
        case (stateCounter)
            IDLE:    nextState = bus.recieverInput ? IDLE : START;
            START:   nextState = SEND;
            SEND:    nextState = (recieveCounter == 3'd7) ? STOP : SEND;
            STOP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bit 0 is sampled on the START->SEND edge, bit 7 on the SEND->STOP edge.
    assign shiftEn = (nextState == SEND) || ((stateCounter == SEND) && (nextState == STOP));

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateCounter   <= IDLE;
            recieveCounter <= 3'd0;
            byteRecieved_q <= 8'd0;
            done_q         <= 1'b0;
        end else begin
            stateCounter <= nextState;
            done_q       <= (stateCounter == STOP) && bus.recieverInput;
            if (shiftEn) begin
                byteRecieved_q <= {bus.recieverInput, byteRecieved_q[7:1]};
                recieveCounter <= recieveCounter + 3'd1;
            end
        end
    end

    assign bus.byteRecieved = byteRecieved_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: reset, start detect, shifting, full frames,
// framing error, back-to-back frames and mid-frame reset.
module tb_uart_receiver;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    uart_receiver_if u_if ();

    uart_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a complete frame starting with the start bit on the next edge.
    task automatic send_frame(input logic [7:0] data, input logic stopb, input string tag);
        u_if.recieverInput = 1'b0;
        tick();
        check({tag, " start state"}, 32'(dut.stateCounter), 32'd1);
        for (int i = 0; i < 8; i++) begin
            u_if.recieverInput = data[i];
            tick();
            check({tag, " done low in frame"}, 32'(u_if.done), 32'd0);
            check({tag, " cnt"}, 32'(dut.recieveCounter), 32'((i + 1) % 8));
            check({tag, " state"}, 32'(dut.stateCounter), (i == 7) ? 32'd3 : 32'd2);
        end
        check({tag, " byte after bit7"}, 32'(u_if.byteRecieved), 32'(data));
        u_if.recieverInput = stopb;
        tick();
        check({tag, " done at stop"}, 32'(u_if.done), 32'(stopb));
        check({tag, " state after stop"}, 32'(dut.stateCounter), 32'd0);
        check({tag, " byte at stop"}, 32'(u_if.byteRecieved), 32'(data));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b0;
        u_if.recieverInput = 1'b1;

        // Reset in idle
        tick();
        check("rst state", 32'(dut.stateCounter), 32'd0);
        check("rst next", 32'(dut.nextState), 32'd0);
        check("rst byte", 32'(u_if.byteRecieved), 32'd0);
        check("rst done", 32'(u_if.done), 32'd0);
        check("rst cnt", 32'(dut.recieveCounter), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle state", 32'(dut.stateCounter), 32'd0);
            check("idle next", 32'(dut.nextState), 32'd0);
            check("idle byte", 32'(u_if.byteRecieved), 32'd0);
            check("idle done", 32'(u_if.done), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("rst2 state", 32'(dut.stateCounter), 32'd0);
        check("rst2 done", 32'(u_if.done), 32'd0);

        // Start detect, then shift of 0xAA
        rst = 1'b1;
        u_if.recieverInput = 1'b1;
        tick();
        u_if.recieverInput = 1'b0;
        #1;
        check("sd state", 32'(dut.stateCounter), 32'd0);
        check("sd next", 32'(dut.nextState), 32'd1);
        tick();
        check("sd state2", 32'(dut.stateCounter), 32'd1);
        check("sd next2", 32'(dut.nextState), 32'd2);
        check("sd byte", 32'(u_if.byteRecieved), 32'd0);
        check("sd done", 32'(u_if.done), 32'd0);
        u_if.recieverInput = 1'b0;
        tick();
        check("aa b0 state", 32'(dut.stateCounter), 32'd2);
        check("aa b0 cnt", 32'(dut.recieveCounter), 32'd1);
        check("aa b0 byte", 32'(u_if.byteRecieved), 32'h00);
        u_if.recieverInput = 1'b1;
        tick();
        check("aa b1 cnt", 32'(dut.recieveCounter), 32'd2);
        check("aa b1 byte", 32'(u_if.byteRecieved), 32'h80);
        for (int i = 2; i < 8; i++) begin
            u_if.recieverInput = (i % 2 == 1);
            tick();
        end
        check("aa state", 32'(dut.stateCounter), 32'd3);
        check("aa byte", 32'(u_if.byteRecieved), 32'hAA);
        u_if.recieverInput = 1'b1;
        tick();
        check("aa done", 32'(u_if.done), 32'd1);
        check("aa final byte", 32'(u_if.byteRecieved), 32'hAA);
        tick();
        check("aa done clear", 32'(u_if.done), 32'd0);

        // Full frame 0xA5 and hold after done
        send_frame(8'hA5, 1'b1, "a5");
        u_if.recieverInput = 1'b1;
        tick();
        check("a5 done clear", 32'(u_if.done), 32'd0);
        check("a5 byte hold", 32'(u_if.byteRecieved), 32'hA5);
        check("a5 idle", 32'(dut.stateCounter), 32'd0);

        // Framing error: line stays low after the bad stop bit
        send_frame(8'h3C, 1'b0, "3c");
        u_if.recieverInput = 1'b0;
        tick();
        check("3c restart state", 32'(dut.stateCounter), 32'd1);
        check("3c restart done", 32'(u_if.done), 32'd0);
        rst = 1'b0;
        u_if.recieverInput = 1'b1;
        tick();
        rst = 1'b1;
        tick();

        // Back-to-back frames with no idle gap
        send_frame(8'h12, 1'b1, "b2b1");
        send_frame(8'h34, 1'b1, "b2b2");
        u_if.recieverInput = 1'b1;
        tick();
        check("b2b done clear", 32'(u_if.done), 32'd0);

        // Mid-frame reset, then a clean frame
        u_if.recieverInput = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            u_if.recieverInput = 1'b1;
            tick();
        end
        check("mid pre cnt", 32'(dut.recieveCounter), 32'd3);
        rst = 1'b0;
        tick();
        check("mid state", 32'(dut.stateCounter), 32'd0);
        check("mid cnt", 32'(dut.recieveCounter), 32'd0);
        check("mid byte", 32'(u_if.byteRecieved), 32'd0);
        check("mid done", 32'(u_if.done), 32'd0);
        rst = 1'b1;
        u_if.recieverInput = 1'b1;
        tick();
        send_frame(8'h81, 1'b1, "81");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
